// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches one instruction at a time, reads a register
// file, drives an external ALU and writes results back. Optional debug read port
// via `define CU_DEBUG_PORT_EN.
module control_unit #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              illegal,
  output logic              halted
`ifdef CU_DEBUG_PORT_EN
  ,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALTED
  } state_t;

  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic [7:0] imm8;

  assign op   = instr_q[15:12];
  assign rd   = instr_q[11:8];
  assign rs1  = instr_q[7:4];
  assign rs2  = instr_q[3:0];
  assign imm8 = instr_q[7:0];

  assign instr_ready = (state == IDLE);

  function automatic logic is_legal(input logic [3:0] o);
    return (o <= OP_DIV) || (o == OP_LDI) || (o == OP_HALT);
  endfunction

  // illegal is decoded at acceptance so its pulse lines up with the DECODE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      instr_q      <= '0;
      alu_opcode   <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      wb_data      <= '0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      halted       <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            illegal <= !is_legal(instr[15:12]);
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (!is_legal(op)) begin
            state <= IDLE;
          end else if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= HALTED;
          end else if (op == OP_LDI) begin
            wb_data <= DATA_W'(imm8);
            done    <= 1'b1;
            state   <= WRITEBACK;
          end else begin
            alu_opcode   <= op;
            alu_operand1 <= regs[rs1];
            alu_operand2 <= regs[rs2];
            state        <= EXECUTE;
          end
        end
        EXECUTE: begin
          wb_data <= alu_result;
          done    <= 1'b1;
          state   <= WRITEBACK;
        end
        WRITEBACK: begin
          regs[rd] <= wb_data;
          state    <= IDLE;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CU_DEBUG_PORT_EN
  assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit with a small behavioural ALU model.
// Debug-port step is included when CU_DEBUG_PORT_EN is defined.
module tb_control_unit;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_operand1;
  logic [DATA_W-1:0] alu_operand2;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] wb_data;
  logic              done;
  logic              illegal;
  logic              halted;
`ifdef CU_DEBUG_PORT_EN
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;
`endif

  int checks = 0;
  int errors = 0;

  control_unit #(.DATA_W(DATA_W), .NREGS(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_ready(instr_ready),
    .alu_opcode(alu_opcode),
    .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2),
    .alu_result(alu_result),
    .wb_data(wb_data),
    .done(done),
    .illegal(illegal),
    .halted(halted)
`ifdef CU_DEBUG_PORT_EN
    ,
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU: truncating arithmetic, divide-by-zero yields 0
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      4'h0: alu_result = alu_operand1 + alu_operand2;
      4'h1: alu_result = alu_operand1 - alu_operand2;
      4'h2: alu_result = alu_operand1 << alu_operand2[3:0];
      4'h3: alu_result = alu_operand1 * alu_operand2;
      4'h4: alu_result = (alu_operand2 == '0) ? '0 : alu_operand1 / alu_operand2;
      default: alu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] ins);
    instr_valid = v;
    instr       = ins;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic issue(input logic [15:0] ins);
    int n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("issue_ready", instr_ready, 1);
    applyStimulus(1'b1, ins);
    tick();
    applyStimulus(1'b0, 16'h0000);
  endtask

  task automatic runLdi(input string tag, input logic [15:0] ins);
    issue(ins);
    checkOutput({tag, ".decode_done"}, done, 0);
    tick();
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".wb_data"}, wb_data, {24'h0, ins[7:0]});
    tick();
  endtask

  task automatic runAlu(input string tag, input logic [15:0] ins, input logic [15:0] exp_op1,
                        input logic [15:0] exp_op2, input logic [15:0] exp_wb);
    issue(ins);
    checkOutput({tag, ".decode_done"}, done, 0);
    tick();
    checkOutput({tag, ".opcode"}, alu_opcode, {28'h0, ins[15:12]});
    checkOutput({tag, ".operand1"}, alu_operand1, exp_op1);
    checkOutput({tag, ".operand2"}, alu_operand2, exp_op2);
    checkOutput({tag, ".exec_done"}, done, 0);
    tick();
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".wb_data"}, wb_data, exp_wb);
    tick();
    checkOutput({tag, ".done_clear"}, done, 0);
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, ".opcode"}, alu_opcode, 0);
    checkOutput({tag, ".operand1"}, alu_operand1, 0);
    checkOutput({tag, ".operand2"}, alu_operand2, 0);
    checkOutput({tag, ".wb_data"}, wb_data, 0);
    checkOutput({tag, ".done"}, done, 0);
    checkOutput({tag, ".illegal"}, illegal, 0);
    checkOutput({tag, ".halted"}, halted, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput({tag, ".ready"}, instr_ready, 1);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000);
`ifdef CU_DEBUG_PORT_EN
    dbg_addr = 4'd0;
`endif
    tick();
    doReset("reset0");

    // ADD path and readback of the written register
    runLdi("ldi_r1_100", 16'hE164);
    runLdi("ldi_r2_100", 16'hE264);
    runAlu("add_r3", 16'h0312, 16'd100, 16'd100, 16'd200);
    runAlu("readback_r3", 16'h1630, 16'd200, 16'd0, 16'd200);
    runAlu("shift_r10", 16'h2A12, 16'd100, 16'd100, 16'h0640);
    runAlu("mul_r11", 16'h3B12, 16'd100, 16'd100, 16'h2710);
    runAlu("div0_r12", 16'h4C10, 16'd100, 16'd0, 16'h0000);
    runAlu("div_r13", 16'h4D21, 16'd100, 16'd100, 16'h0001);

    // SUB with instr_valid held high: one acceptance every 4 cycles
    runLdi("ldi_r1_50", 16'hE132);
    runLdi("ldi_r2_100b", 16'hE264);
    applyStimulus(1'b1, 16'h1412);
    for (int k = 0; k < 8; k++) begin
      checkOutput("b2b.ready", instr_ready, (k % 4 == 0) ? 1 : 0);
      checkOutput("b2b.done", done, (k % 4 == 3) ? 1 : 0);
      if (k % 4 == 2) begin
        checkOutput("b2b.operand1", alu_operand1, 16'd50);
        checkOutput("b2b.operand2", alu_operand2, 16'd100);
      end
      if (k % 4 == 3) begin
        checkOutput("b2b.wb_data", wb_data, 16'hFFCE);
      end
      tick();
    end
    applyStimulus(1'b0, 16'h0000);

    // Illegal opcode 0x7 targeting r1
    issue(16'h7123);
    checkOutput("illegal.pulse", illegal, 1);
    checkOutput("illegal.done", done, 0);
    checkOutput("illegal.ready_decode", instr_ready, 0);
    tick();
    checkOutput("illegal.clear", illegal, 0);
    checkOutput("illegal.done2", done, 0);
    checkOutput("illegal.ready_back", instr_ready, 1);
    checkOutput("illegal.hold_opcode", alu_opcode, 4'h1);
    checkOutput("illegal.hold_op1", alu_operand1, 16'd50);
    checkOutput("illegal.hold_op2", alu_operand2, 16'd100);
    runAlu("after_illegal", 16'h0712, 16'd50, 16'd100, 16'd150);

    // HALT then ignored instructions, then reset clears the register file
    issue(16'hF000);
    checkOutput("halt.decode", halted, 0);
    tick();
    checkOutput("halt.halted", halted, 1);
    checkOutput("halt.ready", instr_ready, 0);
    applyStimulus(1'b1, 16'hE155);
    for (int k = 0; k < 10; k++) begin
      checkOutput("halt.hold_ready", instr_ready, 0);
      checkOutput("halt.hold_halted", halted, 1);
      checkOutput("halt.hold_done", done, 0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000);
    doReset("reset_halt");
    runAlu("cleared_r1_r2", 16'h0012, 16'd0, 16'd0, 16'd0);
    runAlu("cleared_r7", 16'h0070, 16'd0, 16'd0, 16'd0);

    // Reset during EXECUTE aborts the writeback
    runLdi("ldi_r1_7", 16'hE107);
    runLdi("ldi_r2_8", 16'hE208);
    issue(16'h0312);
    tick();
    checkOutput("abort.operand1", alu_operand1, 16'd7);
    checkOutput("abort.operand2", alu_operand2, 16'd8);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.done", done, 0);
    checkOutput("abort.opcode", alu_opcode, 0);
    checkOutput("abort.op1", alu_operand1, 0);
    checkOutput("abort.op2", alu_operand2, 0);
    checkOutput("abort.wb_data", wb_data, 0);
    checkOutput("abort.ready", instr_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("abort.done_edge", done, 0);
    rst_n = 1'b1;
    tick();
    runAlu("abort_r3_zero", 16'h0531, 16'd0, 16'd0, 16'd0);

`ifdef CU_DEBUG_PORT_EN
    runLdi("ldi_r5_ab", 16'hE5AB);
    dbg_addr = 4'd5;
    #1;
    checkOutput("dbg.r5", dbg_data, 16'h00AB);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, default 16, datapath and register width.
- NREGS, default 16, register-file depth, addressed by 4 bits.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- instr_valid  in  1  instruction offered.
- instr  in  16  fields: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2; [7:0] imm8 for LDI.
- instr_ready  out  1  block can accept an instruction.
- alu_opcode  out  4  registered opcode to the ALU.
- alu_operand1  out  DATA_W  registered operand1 to the ALU.
- alu_operand2  out  DATA_W  registered operand2 to the ALU.
- alu_result  in  DATA_W  combinational ALU result.
- wb_data  out  DATA_W  value being written back.
- done  out  1  one-cycle pulse when a writeback completes.
- illegal  out  1  one-cycle pulse when an instruction is illegal.
- halted  out  1  level; high once HALT has executed.

Function
REQ-003 The FSM SHALL have the states IDLE, DECODE, EXECUTE, WRITEBACK and HALTED.
REQ-004 instr_ready SHALL be 1 only in IDLE; an instruction is accepted on an edge where instr_valid and instr_ready are both 1; instr_valid in any other state is ignored.
REQ-005 On acceptance, instr SHALL be latched and the FSM SHALL move to DECODE.
REQ-006 Legal opcodes SHALL be:
- 0x0 ADD, 0x1 SUB, 0x2 SHIFT, 0x3 MUL, 0x4 DIV (ALU operations).
- 0xE LDI.
- 0xF HALT.
- All others (0x5-0xD) are illegal.
REQ-007 DECODE for an ALU op SHALL load alu_opcode=op, alu_operand1=R[rs1] and alu_operand2=R[rs2], then go to EXECUTE.
REQ-008 EXECUTE SHALL capture alu_result into wb_data, then go to WRITEBACK.
REQ-009 DECODE for LDI SHALL load wb_data={zero-extend imm8}, then go directly to WRITEBACK.
REQ-010 WRITEBACK SHALL assert done for one cycle and write R[rd]=wb_data at the end of that cycle, then go to IDLE.
REQ-011 ALU-op latency SHALL be done asserted in the 3rd cycle after the acceptance edge; LDI latency SHALL be the 2nd cycle.
REQ-012 An illegal op SHALL pulse illegal for one cycle in DECODE, perform no register write and no done, and return to IDLE.
REQ-013 HALT SHALL go from DECODE to HALTED; halted=1 and instr_ready=0 thereafter, exited only by reset.
REQ-014 Register reads in DECODE SHALL see all previously completed writebacks; rd may equal rs1 or rs2.
REQ-015 The block SHALL NOT alter ALU results; width truncation and divide-by-zero=0 are ALU behaviour, passed through unchanged.
REQ-016 alu_opcode and the alu_operand outputs SHALL hold their values outside DECODE.

Reset
REQ-017 While rst_n=0 the block SHALL hold:
- State=IDLE.
- All registers R[*]=0.
- alu_opcode=0, alu_operand1=0, alu_operand2=0, wb_data=0.
- done=0, illegal=0, halted=0.
- instr_ready=1 immediately after deassertion.
REQ-018 Reset asserted mid-instruction SHALL abort it with no register write and no done pulse.

Configuration
REQ-019 With CU_DEBUG_PORT_EN defined, the block SHALL add the ports:
- dbg_addr  in  4.
- dbg_data  out  DATA_W, equal to R[dbg_addr] combinationally.
REQ-020 Without CU_DEBUG_PORT_EN, these ports SHALL be absent; all other behaviour is identical.

Verification
REQ-021 The bench SHALL cover these scenarios:
- LDI r1,100; LDI r2,100; ADD r3,r1,r2 -> alu_operand1=alu_operand2=100, opcode 0; wb_data=200 with done; R3=200.
- LDI r1,50; LDI r2,100; SUB r4,r1,r2 -> wb_data=0xFFCE; back-to-back instr_valid held high -> instr_ready high only in IDLE, one instruction per 4 cycles.
- op=0x7 -> illegal pulses once, no done, register file unchanged, instr_ready returns next cycle.
- HALT, then instr_valid=1 for 10 cycles -> halted=1, instr_ready=0, nothing accepted; rst_n low -> IDLE, R[*]=0.
- ADD accepted, rst_n pulsed low during EXECUTE -> no done, R[rd]=0, all outputs 0.
- With CU_DEBUG_PORT_EN: LDI r5,0xAB; dbg_addr=5 -> dbg_data=0x00AB.
